serial_tx: RTL

- UART transmitter. Serialises one byte per handshake onto a single line: 8N1 framing, LSB first, fixed baud set by a clock-divider parameter.
- Sits between the message/print logic and the board TX pin.
- Consumes the `tx_data` / `new_tx_data` / `tx_busy` handshake that the print logic drives. Producer side raises `new_data` only when `busy` is low.

---
 rtl/serial_pkg.sv | 12 +
 rtl/serial_tx_baud_tick.sv | 19 +
 rtl/serial_tx.sv | 100 ++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: state encoding and default bit period shared by serial_tx and serial_rx.
package serial_pkg;
    localparam int STATE_SIZE = 3;
    localparam int DEFAULT_CLK_PER_BIT = 100;
    typedef enum logic [STATE_SIZE-1:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA       = 3'd2,
        STOP_BIT   = 3'd3,
        PARITY_BIT = 3'd4
    } state_t;
endpackage

// File: rtl/serial_tx_baud_tick.sv
// baud_tick: bit-period counter emitting a one-cycle tick at the end of each period.
module baud_tick
    import serial_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int CTR_SIZE = $clog2(CLK_PER_BIT)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_tick
);
    logic [CTR_SIZE-1:0] r_ctr;
    assign o_tick = r_ctr == CTR_SIZE'(CLK_PER_BIT - 1);
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_ctr <= '0;
        else r_ctr <= (i_clear || o_tick) ? '0 : r_ctr + CTR_SIZE'(1);
    end
endmodule

// File: rtl/serial_tx.sv
// serial_tx: UART transmitter, 8N1 LSB first; defining SERIAL_TX_PARITY_EN
// inserts an even-parity bit between the data bits and the stop bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int CTR_SIZE = $clog2(CLK_PER_BIT)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_block,
    input  logic [7:0] i_data,
    input  logic       i_new_data,
    output logic       o_busy,
    output logic       o_tx
);
    state_t     r_state, w_state_next;
    logic [2:0] r_bit, w_bit_next, w_bit_inc;
    logic [7:0] r_data, w_data_next;
    logic       r_tx, w_tx_next, r_busy, w_busy_next, w_tick, w_clear;
    // counter restarts on every state entry so each bit gets a full period
    assign w_clear = (w_state_next != r_state) || (r_state == IDLE);
    assign w_bit_inc = r_bit + 3'd1;
    assign o_busy = r_busy;
    assign o_tx = r_tx;
    baud_tick #(.CLK_PER_BIT(CLK_PER_BIT), .CTR_SIZE(CTR_SIZE)) u_baud_tick (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_clear(w_clear),
        .o_tick(w_tick)
    );
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_bit <= '0;
            r_data <= '0;
            r_tx <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_bit <= w_bit_next;
            r_data <= w_data_next;
            r_tx <= w_tx_next;
            r_busy <= w_busy_next;
        end
    end
    always_comb begin
        w_state_next = r_state;
        w_bit_next = r_bit;
        w_data_next = r_data;
        w_tx_next = r_tx;
        w_busy_next = r_busy;
        case (r_state)
            IDLE: begin
                w_tx_next = 1'b1;
                w_busy_next = i_block;
                if (i_new_data && !r_busy) begin
                    w_state_next = START_BIT;
                    w_data_next = i_data;
                    w_tx_next = 1'b0;
                    w_busy_next = 1'b1;
                end
            end
            START_BIT: if (w_tick) begin
                w_state_next = DATA;
                w_bit_next = 3'd0;
                w_tx_next = r_data[0];
            end
            DATA: if (w_tick) begin
                if (r_bit == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                    w_state_next = PARITY_BIT;
                    w_tx_next = ^r_data;
`else
                    w_state_next = STOP_BIT;
                    w_tx_next = 1'b1;
`endif
                end else begin
                    w_bit_next = w_bit_inc;
                    w_tx_next = r_data[w_bit_inc];
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY_BIT: if (w_tick) begin
                w_state_next = STOP_BIT;
                w_tx_next = 1'b1;
            end
`endif
            STOP_BIT: if (w_tick) begin
                w_state_next = IDLE;
                w_tx_next = 1'b1;
                w_busy_next = i_block;
            end
            default: begin
                w_state_next = IDLE;
                w_tx_next = 1'b1;
            end
        endcase
    end
endmodule
